// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: producers push at clock rate, the FSM
// launches one byte per frame and waits for the transmitter's Active/Done handshake.
module uart_tx_fifo #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Wr_DV,
    input  logic [7:0]            i_Wr_Byte,
    input  logic                  i_Flush,
    output logic                  o_Full,
    output logic                  o_Empty,
    output logic [ADDR_WIDTH:0]   o_Count,
    output logic                  o_Overflow,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    input  logic                  i_TX_Active,
    input  logic                  i_TX_Done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACT  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  launch;
    logic                  wr_accept;
    logic                  wr_dropped;

    // A flush cycle swallows any same-cycle write silently, without an overflow pulse.
    assign wr_accept  = i_Wr_DV && !o_Full && !i_Flush;
    assign wr_dropped = i_Wr_DV &&  o_Full && !i_Flush;
    assign o_Count    = count;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!o_Empty && !i_TX_Active && !i_Flush) begin
                    launch    = 1'b1;
                    state_nxt = WAIT_ACT;
                end
            end
            WAIT_ACT: begin
                // Done before Active covers a transmitter that drops Active early.
                if (i_TX_Done) begin
                    state_nxt = IDLE;
                end else if (i_TX_Active) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_TX_Done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (i_Flush) begin
            count_nxt = '0;
        end else begin
            unique case ({wr_accept, launch})
                2'b10:   count_nxt = count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count_nxt = count - (ADDR_WIDTH + 1)'(1);
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            o_Empty    <= 1'b1;
            o_Full     <= 1'b0;
            o_Overflow <= 1'b0;
            o_TX_DV    <= 1'b0;
            o_TX_Byte  <= 8'h00;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            o_Empty    <= (count_nxt == '0);
            o_Full     <= (count_nxt == DEPTH_CNT);
            o_Overflow <= wr_dropped;
            o_TX_DV    <= launch;
            if (launch) begin
                o_TX_Byte <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
            end else if (i_Flush) begin
                rd_ptr <= wr_ptr;
            end
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_Clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= i_Wr_Byte;
        end
    end

endmodule
